// File: rtl/input_cond_pkg.sv
// Shared constants, cycle-conversion helper and per-channel status type for input_conditioner.
package input_cond_pkg;

  localparam int unsigned CLK_HZ = 125_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(10);
  localparam int unsigned DEFAULT_HOLD_CYCLES     = ms_to_cycles(1000);

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic hold;
  } chan_status_t;

endpackage

// File: rtl/debounce_cell.sv
// One channel: 2-FF synchroniser, counter debouncer, edge pulses and optional hold detector.
// Hold detection is built only when INPUT_CONDITIONER_HOLD_DETECT_EN is defined.
module debounce_cell
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         raw,
  output chan_status_t status
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_params
    $error("debounce_cell: DEBOUNCE_CYCLES and HOLD_CYCLES must be at least 2");
  end

  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Any cycle where s2 matches level discards the partial count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = s2_q;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign status.level = level_q;
  assign status.rise  = rise_q;
  assign status.fall  = fall_q;

`ifdef INPUT_CONDITIONER_HOLD_DETECT_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);

  logic [HoldW-1:0] hcnt_q, hcnt_d;
  logic             hold_q, hold_d;

  // Saturating at HoldMax keeps a long press from pulsing again.
  always_comb begin
    hcnt_d = '0;
    hold_d = 1'b0;
    if (level_q) begin
      hold_d = (hcnt_q == HoldLast);
      hcnt_d = (hcnt_q == HoldMax) ? hcnt_q : hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign status.hold = hold_q;
`else
  assign status.hold = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: one debounce_cell per raw input.
// hold[] pulses only when INPUT_CONDITIONER_HOLD_DETECT_EN is defined, otherwise it stays 0.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic [N_IN-1:0] hold
);

  chan_status_t status [N_IN];

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .status(status[i])
    );
  end

  always_comb begin
    level = '0;
    rise  = '0;
    fall  = '0;
    hold  = '0;
    for (int i = 0; i < N_IN; i++) begin
      level[i] = status[i].level;
      rise[i]  = status[i].rise;
      fall[i]  = status[i].fall;
      hold[i]  = status[i].hold;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random stimulus against a
// sliding-window reference model.
module tb_input_conditioner;

  localparam int unsigned NIn  = 4;
  localparam int unsigned Deb  = 16;
  localparam int unsigned Hold = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NIn-1:0] raw_in;
  logic [NIn-1:0] level, rise, fall, hold;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned edge_no  = 0;

  // Model: newest raw sample in bit 0; bits [Deb+1:2] are the samples the debouncer has judged.
  logic [Deb+1:0] win [NIn];
  logic [NIn-1:0] m_level, m_rise, m_fall, m_hold;
  int unsigned    age [NIn];

  int unsigned rise_seen [NIn];
  int unsigned fall_seen [NIn];
  int unsigned hold_seen [NIn];
  int unsigned last_rise [NIn];
  int unsigned last_fall [NIn];
  int unsigned last_hold [NIn];

  input_conditioner #(
    .N_IN           (NIn),
    .DEBOUNCE_CYCLES(Deb),
    .HOLD_CYCLES    (Hold)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(raw_in),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .hold  (hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
  endtask

  task automatic clear_model();
    for (int ch = 0; ch < NIn; ch++) begin
      win[ch] = '0;
      age[ch] = 0;
    end
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_hold  = '0;
  endtask

  task automatic mark();
    for (int ch = 0; ch < NIn; ch++) begin
      rise_seen[ch] = 0;
      fall_seen[ch] = 0;
      hold_seen[ch] = 0;
    end
  endtask

  // A level flips once the last Deb judged samples all disagree with it.
  task automatic model_edge(input logic [NIn-1:0] r);
    for (int ch = 0; ch < NIn; ch++) begin
      logic [Deb-1:0] w;
      win[ch] = {win[ch][Deb:0], r[ch]};
      w = win[ch][Deb+1:2];
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      m_hold[ch] = 1'b0;
      if (m_level[ch]) begin
        age[ch]++;
        m_hold[ch] = (age[ch] == Hold);
      end
      if (w == {Deb{~m_level[ch]}}) begin
        m_level[ch] = ~m_level[ch];
        m_rise[ch]  = m_level[ch];
        m_fall[ch]  = ~m_level[ch];
        age[ch]     = 0;
      end
    end
`ifndef INPUT_CONDITIONER_HOLD_DETECT_EN
    m_hold = '0;
`endif
  endtask

  task automatic step(input logic [NIn-1:0] r);
    raw_in = r;
    @(posedge clk);
    edge_no++;
    model_edge(r);
    #1;
    check("level", level, m_level);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("hold", hold, m_hold);
    for (int ch = 0; ch < NIn; ch++) begin
      if (rise[ch]) begin rise_seen[ch]++; last_rise[ch] = edge_no; end
      if (fall[ch]) begin fall_seen[ch]++; last_fall[ch] = edge_no; end
      if (hold[ch]) begin hold_seen[ch]++; last_hold[ch] = edge_no; end
    end
  endtask

  // Assert reset between edges, check outputs clear at once, release between edges.
  task automatic do_reset(input logic [NIn-1:0] r, input int unsigned cycles);
    raw_in = r;
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 32'h0);
    check("rst_rise", rise, 32'h0);
    check("rst_fall", fall, 32'h0);
    check("rst_hold", hold, 32'h0);
    clear_model();
    repeat (cycles) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [NIn-1:0] r;
    int unsigned t0;
    int unsigned rate [NIn];

    rst_n  = 1'b0;
    raw_in = 4'hF;
    clear_model();
    mark();
    repeat (2) @(posedge clk);
    #1;
    check("init_level", level, 32'h0);
    check("init_rise", rise, 32'h0);
    check("init_fall", fall, 32'h0);
    check("init_hold", hold, 32'h0);
    #2 rst_n = 1'b1;

    // Release with all pins high
    t0 = edge_no;
    repeat (22) step(4'hF);
    for (int ch = 0; ch < NIn; ch++) begin
      check("t1_rise_n", rise_seen[ch], 1);
      check("t1_rise_at", last_rise[ch] - t0, 18);
    end

    // Short glitch on channel 0
    do_reset(4'h0, 2);
    repeat (5) step(4'h0);
    mark();
    repeat (10) step(4'h1);
    repeat (20) step(4'h0);
    check("t2_rise_n", rise_seen[0], 0);
    check("t2_fall_n", fall_seen[0], 0);
    check("t2_level", level[0], 0);

    // Bouncing channel 1, then held high
    mark();
    r  = '0;
    t0 = edge_no;
    for (int i = 0; i < 30; i++) begin
      r[1] = ((i / 3) % 2) == 1;
      if (r != raw_in) t0 = edge_no;
      step(r);
    end
    repeat (30) step(r);
    check("t3_rise_n", rise_seen[1], 1);
    check("t3_rise_at", last_rise[1] - t0, 18);

    // Channel 2 released after being stable high
    r = 4'b0110;
    repeat (20) step(r);
    mark();
    t0   = edge_no;
    r[2] = 1'b0;
    repeat (25) step(r);
    check("t4_fall_n", fall_seen[2], 1);
    check("t4_fall_at", last_fall[2] - t0, 18);
    check("t4_rise_n", rise_seen[2], 0);
    check("t4_level", level[2], 0);

    // Long press on channel 3
    r = 4'b1010;
    mark();
    repeat (200) step(r);
`ifdef INPUT_CONDITIONER_HOLD_DETECT_EN
    check("t5_hold_n", hold_seen[3], 1);
    check("t5_hold_at", last_hold[3] - last_rise[3], 64);
`else
    check("t5_hold_n", hold_seen[3], 0);
`endif
    r = '0;
    repeat (25) step(r);

    // Reset in the middle of a count
    mark();
    r = 4'b0001;
    repeat (12) step(r);
    do_reset(r, 2);
    mark();
    t0 = edge_no;
    repeat (25) step(r);
    check("t6_rise_n", rise_seen[0], 1);
    check("t6_rise_at", last_rise[0] - t0, 18);

    // Random bouncing with mixed toggle rates and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      for (int ch = 0; ch < NIn; ch++) rate[ch] = $urandom_range(0, 2) == 0 ? 3 : 40;
      for (int i = 0; i < 200; i++) begin
        for (int ch = 0; ch < NIn; ch++)
          if ($urandom_range(0, rate[ch]) == 0) r[ch] = ~r[ch];
        if ($urandom_range(0, 799) == 0) do_reset(r, $urandom_range(1, 4));
        step(r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
